// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package mem_arb_pkg;

  localparam int ARB_ADDR_W     = 32;
  localparam int ARB_DATA_W     = 32;
  localparam int ARB_LS_MAX_WIN = 4;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RSP} arb_state_e;
  typedef enum logic       {OWN_IF, OWN_LS}             arb_owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between IF and LS with an LS win counter that bounds IF starvation.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int LS_MAX_WIN = ARB_LS_MAX_WIN
) (
  input  logic clk,
  input  logic rst,
  input  logic if_valid,
  input  logic ls_valid,
  input  logic fire,
  output logic grant_if,
  output logic grant_ls
);

  localparam int CNT_W = $clog2(LS_MAX_WIN + 1);

  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic             at_limit;

  // Grant: LS preferred on contention until it has won LS_MAX_WIN times in a row.
  always_comb begin
    at_limit = (win_cnt_q == CNT_W'(LS_MAX_WIN));
    grant_if = if_valid & (~ls_valid | at_limit);
    grant_ls = ls_valid & ~grant_if;
  end

  // Counter: counts LS wins taken while IF was waiting; anything else clears it.
  always_comb begin
    win_cnt_d = win_cnt_q;
    if (fire) begin
      if (grant_ls & if_valid) win_cnt_d = at_limit ? win_cnt_q : win_cnt_q + CNT_W'(1);
      else                     win_cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) win_cnt_q <= '0;
    else     win_cnt_q <= win_cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (IF, read-only) and load/store (LS).
// One transaction in flight; the response is steered back to the grant owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int LS_MAX_WIN = ARB_LS_MAX_WIN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  input  logic                if_rsp_ready,
  output logic [DATA_W-1:0]   if_rsp_rdata,
  output logic                if_rsp_err,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_we,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wstrb,
  output logic                ls_rsp_valid,
  input  logic                ls_rsp_ready,
  output logic [DATA_W-1:0]   ls_rsp_rdata,
  output logic                ls_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  input  logic                mem_rsp_err
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;

  logic idle, in_req, in_rsp, own_if, own_ls;
  logic grant_if, grant_ls, fire, rsp_fire;

  // rst masks every handshake output, whatever state the register still holds.
  assign idle   = ~rst & (state_q == ARB_IDLE);
  assign in_req = ~rst & (state_q == ARB_REQ);
  assign in_rsp = ~rst & (state_q == ARB_RSP);
  assign own_if = in_rsp & (owner_q == OWN_IF);
  assign own_ls = in_rsp & (owner_q == OWN_LS);

  mem_arb_prio #(.LS_MAX_WIN(LS_MAX_WIN)) u_prio (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_req_valid & idle),
    .ls_valid (ls_req_valid & idle),
    .fire     (fire),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;
  assign fire         = grant_if | grant_ls;

  assign mem_req_valid = in_req;
  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;

  assign if_rsp_valid  = own_if & mem_rsp_valid;
  assign if_rsp_rdata  = own_if ? mem_rsp_rdata : '0;
  assign if_rsp_err    = own_if & mem_rsp_err;
  assign ls_rsp_valid  = own_ls & mem_rsp_valid;
  assign ls_rsp_rdata  = own_ls ? mem_rsp_rdata : '0;
  assign ls_rsp_err    = own_ls & mem_rsp_err;
  assign mem_rsp_ready = (own_if & if_rsp_ready) | (own_ls & ls_rsp_ready);
  assign rsp_fire      = mem_rsp_valid & mem_rsp_ready;

  // Next state and request capture; fields only change on a granted handshake.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      ARB_IDLE: begin
        if (fire) begin
          state_d = ARB_REQ;
          if (grant_if) begin
            owner_d = OWN_IF;
            addr_d  = if_req_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            wstrb_d = '0;
          end else begin
            owner_d = OWN_LS;
            addr_d  = ls_req_addr;
            we_d    = ls_req_we;
            wdata_d = ls_req_wdata;
            wstrb_d = ls_req_wstrb;
          end
        end
      end
      ARB_REQ: if (mem_req_ready) state_d = ARB_RSP;
      ARB_RSP: if (rsp_fire)      state_d = ARB_IDLE;
      default:                    state_d = ARB_IDLE;
    endcase
  end

  // State, owner and request registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

endmodule
